// File: rtl/deserializer_4bit.sv
// Serial-to-parallel receiver for the LSB-first link.
// Start/data/stop framing with a one-deep valid/ready holding register.
module deserializer_4bit #(
    parameter int   WIDTH       = 4,
    parameter logic START_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;

    logic xfer;
    logic free;
    logic last_bit;
    logic stop_ok;

    assign xfer     = dout_valid && dout_ready;
    assign free     = !dout_valid || xfer;
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));
    assign stop_ok  = (din != START_LEVEL);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (xfer) begin
                dout_valid <= 1'b0;
            end
            // Clear first so a same-cycle set event below wins.
            if (clr_err) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (din == START_LEVEL) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg[bit_cnt] <= din;
                        if (last_bit) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                        if (stop_ok) begin
                            if (free) begin
                                dout       <= shift_reg;
                                dout_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializer_4bit.sv
// Bench for deserializer_4bit: directed scenarios plus randomized frames,
// checked by a frame-level model and a scoreboard of delivered words.
module tb_deserializer_4bit;

    logic       clk;
    logic       rst;
    logic       din;
    logic       bit_en;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;

    deserializer_4bit #(.WIDTH(4), .START_LEVEL(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .bit_en     (bit_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Driver-side frame annotation read by the model.
    logic       stop_now  = 1'b0;
    logic       stop_good = 1'b0;
    logic [3:0] stop_word = 4'h0;
    bit         rand_ready = 1'b0;
    bit         rand_clr   = 1'b0;

    logic [3:0] exp_q[$];
    logic       m_valid;
    logic       m_ferr;
    logic       m_over;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
        if (rand_clr) clr_err = ($urandom_range(0, 15) == 0);
        @(posedge clk);
        #2;
    endtask

    // per = strobe period in cycles; sr >= 0 forces dout_ready on the stop strobe.
    task automatic send_frame(input logic [3:0] w, input bit good, input int per, input int sr);
        logic [5:0] bits;
        bits = {good ? 1'b0 : 1'b1, w, 1'b1};
        for (int i = 0; i < 6; i++) begin
            for (int g = 1; g < per; g++) begin
                bit_en   = 1'b0;
                stop_now = 1'b0;
                din      = 1'($urandom_range(0, 1));
                step();
            end
            bit_en    = 1'b1;
            din       = bits[i];
            stop_now  = (i == 5);
            stop_word = w;
            stop_good = good;
            if (i == 5 && sr >= 0) dout_ready = sr[0];
            step();
        end
        bit_en   = 1'b0;
        stop_now = 1'b0;
        din      = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    // Frame-level model: checks flags, then predicts the next edge.
    always @(negedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_over  = 1'b0;
            exp_q.delete();
        end else begin
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("overrun", 32'(overrun), 32'(m_over));
            if (m_valid && dout_ready) m_valid = 1'b0;
            if (clr_err) begin
                m_ferr = 1'b0;
                m_over = 1'b0;
            end
            if (bit_en && stop_now) begin
                if (!stop_good) begin
                    m_ferr = 1'b1;
                end else if (!m_valid) begin
                    m_valid = 1'b1;
                    exp_q.push_back(stop_word);
                end else begin
                    m_over = 1'b1;
                end
            end
        end
    end

    // Monitor: every handshake transfer pops one expected word.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got %0h expected none", dout);
            end else begin
                chk("sb_word", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        din        = 1'b0;
        bit_en     = 1'b0;
        dout_ready = 1'b0;
        clr_err    = 1'b0;
        #1;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // 1: good frame 4'hA with ready high
        dout_ready = 1'b1;
        send_frame(4'hA, 1'b1, 1, -1);
        chk("t1_dout", 32'(dout), 32'hA);
        chk("t1_valid", 32'(dout_valid), 1);
        step();
        chk("t1_valid_fall", 32'(dout_valid), 0);

        // 2: bad stop bit, clear, then good frame
        send_frame(4'hF, 1'b0, 1, -1);
        chk("t2_ferr", 32'(frame_err), 1);
        chk("t2_valid", 32'(dout_valid), 0);
        clr_pulse();
        chk("t2_ferr_clr", 32'(frame_err), 0);
        send_frame(4'h5, 1'b1, 1, -1);
        chk("t2_dout", 32'(dout), 32'h5);
        step();

        // 3: overrun with ready held low
        dout_ready = 1'b0;
        send_frame(4'h3, 1'b1, 1, -1);
        send_frame(4'hC, 1'b1, 1, -1);
        step();
        chk("t3_dout", 32'(dout), 32'h3);
        chk("t3_valid", 32'(dout_valid), 1);
        chk("t3_over", 32'(overrun), 1);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        chk("t3_drain", 32'(dout_valid), 0);
        clr_pulse();

        // 4: same-cycle consume on back-to-back full-rate frames
        send_frame(4'h1, 1'b1, 1, 0);
        send_frame(4'h2, 1'b1, 1, 1);
        dout_ready = 1'b0;
        chk("t4_dout", 32'(dout), 32'h2);
        chk("t4_valid", 32'(dout_valid), 1);
        chk("t4_over", 32'(overrun), 0);
        dout_ready = 1'b1;
        step();

        // 5: reset after two data bits
        bit_en = 1'b1;
        din    = 1'b1;
        step();
        din = 1'b0;
        step();
        din = 1'b1;
        step();
        bit_en = 1'b0;
        chk("t5_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_out", 32'({dout, dout_valid, busy, frame_err, overrun}), 0);
        step();
        rst = 1'b0;
        step();
        send_frame(4'hF, 1'b1, 1, -1);
        chk("t5_dout", 32'(dout), 32'hF);
        step();

        // 6: strobe every third cycle, din toggling between strobes
        send_frame(4'h6, 1'b1, 3, -1);
        chk("t6_dout", 32'(dout), 32'h6);
        step();

        // Randomized frames, gaps, ready and error clears
        rand_ready = 1'b1;
        rand_clr   = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send_frame(4'($urandom_range(0, 15)), ($urandom_range(0, 6) != 0),
                       int'($urandom_range(1, 3)), -1);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_ready = 1'b0;
        rand_clr   = 1'b0;
        clr_err    = 1'b0;
        dout_ready = 1'b1;
        repeat (3) step();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
